sme_feeder: RTL and testbench
=============================

# sme_feeder

Upstream front end for the string-matching engine (SME). Accepts framed string and pattern records over a byte-wide valid/ready stream and buffers them. Replays each record to the SME with the exact isstring/ispattern/chardata sequencing the engine requires. Captures the SME's match/match_index answer and presents it on a held result port.

## Interface
- STR_MAX, 32: maximum string length in characters.
- PAT_MAX, 8: maximum pattern length in characters.
- TIMEOUT, 256: cycles to wait for sme_valid before forcing a no-match result.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- s_valid  in  1  input byte valid
- s_ready  out  1  feeder can accept a byte
- s_data  in  8  record character
- s_kind  in  1  0 = string record, 1 = pattern record; sampled on the first byte of each record
- s_last  in  1  final byte of record
- sme_chardata  out  8  character to SME
- sme_isstring  out  1  string character strobe
- sme_ispattern  out  1  pattern character strobe
- sme_valid  in  1  SME result strobe
- sme_match  in  1  SME match flag
- sme_match_index  in  5  SME match position
- r_valid  out  1  result available
- r_ready  in  1  result consumed
- r_match  out  1  captured match
- r_index  out  5  captured index
- err_overflow  out  1  sticky: record exceeded STR_MAX/PAT_MAX
- err_seq  out  1  sticky: pattern record received with no string loaded since reset
- err_timeout  out  1  sticky: SME did not answer within TIMEOUT

## Operation
- States: IDLE, LOAD, SEND_STR, SEND_PAT, WAIT, RESULT.
- IDLE: s_ready=1. The first accepted byte latches its kind, is written at index 0, and moves to LOAD. If s_last is also high, the record is complete.
- LOAD: s_ready=1. Each accepted byte is written at the next index. On s_last:
  - String record: store str_len, set str_pending=1, str_loaded=1, go to IDLE. Nothing is sent yet.
  - Pattern record with str_loaded=0: discard, set err_seq, go to IDLE.
  - Pattern record with str_pending=1: go to SEND_STR.
  - Otherwise: go to SEND_PAT.
- Overflow: bytes beyond STR_MAX/PAT_MAX are still accepted but dropped. err_overflow is set, the length saturates at max, and the record is otherwise processed normally.
- A new string record overwrites the string buffer and sets str_pending again.
- SEND_STR: drive str[i] with isstring=1 for str_len consecutive cycles, then clear str_pending and go to SEND_PAT with no gap.
- SEND_PAT: drive pat[i] with ispattern=1 for pat_len consecutive cycles, then go to WAIT. In WAIT, both strobes and chardata are 0.
- WAIT: count cycles.
  - On sme_valid: capture sme_match and sme_match_index, go to RESULT.
  - If the count reaches TIMEOUT: capture match=0, index=0, set err_timeout, go to RESULT.
- sme_valid outside WAIT is ignored.
- RESULT: r_valid=1 with r_match/r_index stable until r_ready. On handshake, go to IDLE.

## Timing
- Reset values: s_ready=0, sme_chardata=0, sme_isstring=0, sme_ispattern=0, r_valid=0, r_match=0, r_index=0. All err_* = 0. str_loaded=0, str_pending=0, state IDLE.
- s_ready=1 from the first cycle after reset deasserts.
- All SME-facing outputs are registered.
- The first isstring/ispattern cycle occurs the cycle after the s_last handshake.
- Latency from s_last to the last SME strobe: str_len (if pending) + pat_len cycles.
- s_ready=0 in SEND_STR, SEND_PAT, WAIT, RESULT. Input backpressure is held until the result handshake completes, plus one cycle in IDLE.
- r_valid rises the cycle after sme_valid is sampled, or the cycle after the timeout count hits TIMEOUT.
- Timeout counter: clog2(TIMEOUT+1) bits, cleared on entry to WAIT.
- Index counters: clog2(STR_MAX+1) bits; they never wrap.
- Reset mid-record or mid-send: abort immediately. Strobes drop the next cycle and buffers are marked empty (str_loaded=0).
- The err_* flags clear only on reset.

## Structure
- Package sme_pkg holds:
  - the state enum;
  - STR_MAX, PAT_MAX defaults;
  - KIND_STRING/KIND_PATTERN constants;
  - the SME index width (5).
- One sub-module, sme_char_buf: a parameterised DEPTH×8 register file with write port, read port, and saturating length/overflow flag. It is instantiated twice (string, pattern).

## Test plan
- Load string "abcab" (5 bytes), then pattern "ca". Required: isstring high 5 cycles with a,b,c,a,b, immediately followed by ispattern high 2 cycles with c,a. SME answers match=1, idx=2, giving r_valid, r_match=1, r_index=2.
- A second pattern "zz" after the first result. Required: no isstring cycles, ispattern 2 cycles only. SME answers match=0, giving r_match=0.
- Pattern record sent directly after reset. Required: zero SME strobes, err_seq=1, s_ready back to 1.
- 40-byte string record. Required: all 40 bytes are accepted, isstring is high exactly 32 cycles, and err_overflow=1.
- No sme_valid after the pattern. Required: r_valid exactly TIMEOUT+1 cycles after the last ispattern, with r_match=0, r_index=0, err_timeout=1.
- Reset asserted during SEND_STR. Required: strobes are 0 the next cycle and all outputs are at reset values. A subsequent pattern raises err_seq.

Source files
------------

// File: rtl/sme_pkg.sv
// Shared types and constants for the SME feeder: FSM states, record kinds,
// default buffer depths and the SME match-index width.
package sme_pkg;
  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;
  localparam int IDX_W       = 5;

  localparam logic KIND_STRING  = 1'b0;
  localparam logic KIND_PATTERN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_STR,
    ST_SEND_PAT,
    ST_WAIT,
    ST_RESULT
  } state_t;

  typedef struct packed {
    logic             match;
    logic [IDX_W-1:0] index;
  } sme_result_t;
endpackage

// File: rtl/sme_char_buf.sv
// DEPTH x 8 character store with a saturating length counter; writes past
// DEPTH are dropped and raise ovf until the next record starts.
module sme_char_buf #(
  parameter int DEPTH = 32,
  parameter int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_first,
  input  logic [7:0]       wr_data,
  input  logic [LEN_W-1:0] rd_idx,
  output logic [7:0]       rd_data,
  output logic [LEN_W-1:0] len,
  output logic             ovf
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] FULL = LEN_W'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [LEN_W-1:0] wr_idx;

  assign wr_idx  = wr_first ? '0 : len;
  assign rd_data = (rd_idx < FULL) ? mem[rd_idx[AW-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en && (wr_idx < FULL)) mem[wr_idx[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len <= '0;
      ovf <= 1'b0;
    end else if (wr_en) begin
      if (wr_first) begin
        len <= LEN_W'(1);
        ovf <= 1'b0;
      end else if (len == FULL) begin
        ovf <= 1'b1;
      end else begin
        len <= len + LEN_W'(1);
      end
    end
  end
endmodule

// File: rtl/sme_feeder.sv
// Buffers framed string/pattern records and replays them to the SME with
// back-to-back isstring/ispattern strobes, then holds the SME answer.
module sme_feeder
  import sme_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_kind,
  input  logic             s_last,
  output logic [7:0]       sme_chardata,
  output logic             sme_isstring,
  output logic             sme_ispattern,
  input  logic             sme_valid,
  input  logic             sme_match,
  input  logic [IDX_W-1:0] sme_match_index,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             r_match,
  output logic [IDX_W-1:0] r_index,
  output logic             err_overflow,
  output logic             err_seq,
  output logic             err_timeout
);
  localparam int LEN_W = $clog2(STR_MAX + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t           state;
  sme_result_t      res_q;
  logic             kind_q, str_loaded, str_pending;
  logic [LEN_W-1:0] idx;
  logic [TMO_W-1:0] tmo_cnt;

  logic             accept, first, cur_kind;
  logic [LEN_W-1:0] str_len, pat_len, str_rd_idx, pat_rd_idx;
  logic [7:0]       str_rd, pat_rd;
  logic             str_ovf, pat_ovf;

  assign accept     = s_valid & s_ready;
  assign first      = (state == ST_IDLE);
  assign cur_kind   = first ? s_kind : kind_q;
  assign str_rd_idx = (state == ST_SEND_STR) ? idx : '0;
  assign pat_rd_idx = (state == ST_SEND_PAT) ? idx : '0;
  assign r_match    = res_q.match;
  assign r_index    = res_q.index;

  sme_char_buf #(.DEPTH(STR_MAX), .LEN_W(LEN_W)) u_str_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (accept && (cur_kind == KIND_STRING)),
    .wr_first (first),
    .wr_data  (s_data),
    .rd_idx   (str_rd_idx),
    .rd_data  (str_rd),
    .len      (str_len),
    .ovf      (str_ovf)
  );

  sme_char_buf #(.DEPTH(PAT_MAX), .LEN_W(LEN_W)) u_pat_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (accept && (cur_kind == KIND_PATTERN)),
    .wr_first (first),
    .wr_data  (s_data),
    .rd_idx   (pat_rd_idx),
    .rd_data  (pat_rd),
    .len      (pat_len),
    .ovf      (pat_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      kind_q        <= KIND_STRING;
      str_loaded    <= 1'b0;
      str_pending   <= 1'b0;
      idx           <= '0;
      tmo_cnt       <= '0;
      s_ready       <= 1'b0;
      sme_chardata  <= 8'h00;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
      r_valid       <= 1'b0;
      res_q         <= '0;
      err_overflow  <= 1'b0;
      err_seq       <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      // SME-facing outputs are zero unless a send step below drives them
      sme_chardata  <= 8'h00;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
      s_ready       <= 1'b0;
      if (str_ovf || pat_ovf) err_overflow <= 1'b1;

      case (state)
        ST_IDLE, ST_LOAD: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (first) kind_q <= s_kind;
            state <= ST_LOAD;
            if (s_last) begin
              state <= ST_IDLE;
              if (cur_kind == KIND_STRING) begin
                str_loaded  <= 1'b1;
                str_pending <= 1'b1;
              end else if (!str_loaded) begin
                err_seq <= 1'b1;
              end else if (str_pending) begin
                state        <= ST_SEND_STR;
                s_ready      <= 1'b0;
                sme_isstring <= 1'b1;
                sme_chardata <= str_rd;
                idx          <= LEN_W'(1);
              end else begin
                // a one-byte pattern is still being written, so bypass the buffer
                state         <= ST_SEND_PAT;
                s_ready       <= 1'b0;
                sme_ispattern <= 1'b1;
                sme_chardata  <= first ? s_data : pat_rd;
                idx           <= LEN_W'(1);
              end
            end
          end
        end

        ST_SEND_STR: begin
          if (idx < str_len) begin
            sme_isstring <= 1'b1;
            sme_chardata <= str_rd;
            idx          <= idx + LEN_W'(1);
          end else begin
            str_pending   <= 1'b0;
            state         <= ST_SEND_PAT;
            sme_ispattern <= 1'b1;
            sme_chardata  <= pat_rd;
            idx           <= LEN_W'(1);
          end
        end

        ST_SEND_PAT: begin
          if (idx < pat_len) begin
            sme_ispattern <= 1'b1;
            sme_chardata  <= pat_rd;
            idx           <= idx + LEN_W'(1);
          end else begin
            state   <= ST_WAIT;
            tmo_cnt <= '0;
          end
        end

        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (sme_valid) begin
            state       <= ST_RESULT;
            r_valid     <= 1'b1;
            res_q.match <= sme_match;
            res_q.index <= sme_match_index;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            state       <= ST_RESULT;
            r_valid     <= 1'b1;
            res_q       <= '0;
            err_timeout <= 1'b1;
          end
        end

        ST_RESULT: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench: a record-level model predicts the SME strobe stream and the
// held result; one negedge process compares the strobes every cycle.
module tb_sme_feeder;
  import sme_pkg::*;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int TIMEOUT = 256;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             s_valid = 1'b0, s_kind = 1'b0, s_last = 1'b0;
  logic [7:0]       s_data = 8'h00;
  logic             s_ready;
  logic [7:0]       sme_chardata;
  logic             sme_isstring, sme_ispattern;
  logic             sme_valid = 1'b0, sme_match = 1'b0;
  logic [IDX_W-1:0] sme_match_index = '0;
  logic             r_valid, r_match;
  logic             r_ready = 1'b0;
  logic [IDX_W-1:0] r_index;
  logic             err_overflow, err_seq, err_timeout;

  sme_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_kind(s_kind), .s_last(s_last),
    .sme_chardata(sme_chardata), .sme_isstring(sme_isstring),
    .sme_ispattern(sme_ispattern), .sme_valid(sme_valid),
    .sme_match(sme_match), .sme_match_index(sme_match_index),
    .r_valid(r_valid), .r_ready(r_ready), .r_match(r_match),
    .r_index(r_index), .err_overflow(err_overflow), .err_seq(err_seq),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_str;
    logic [7:0] ch;
  } ev_t;

  int  total = 0, bad = 0;
  int  n_str = 0, n_pat = 0;
  ev_t exp_q[$];
  bit  exp_start = 0, in_burst = 0;

  string m_str = "";
  bit    m_loaded = 0, m_pending = 0;
  bit    m_err_seq = 0, m_err_ovf = 0, m_err_tmo = 0;
  logic             m_rm = 1'b0;
  logic [IDX_W-1:0] m_ri = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Record-level model: what the SME must see once a record completes.
  task automatic model_rec(input logic kind, input string s);
    ev_t e;
    int  n = s.len();
    if (kind == KIND_STRING) begin
      m_str = (n > STR_MAX) ? s.substr(0, STR_MAX - 1) : s;
      if (n > STR_MAX) m_err_ovf = 1;
      m_loaded  = 1;
      m_pending = 1;
    end else begin
      if (n > PAT_MAX) m_err_ovf = 1;
      if (!m_loaded) m_err_seq = 1;
      else begin
        if (m_pending)
          for (int i = 0; i < m_str.len(); i++) begin
            e.is_str = 1'b1; e.ch = m_str[i]; exp_q.push_back(e);
          end
        for (int i = 0; i < n && i < PAT_MAX; i++) begin
          e.is_str = 1'b0; e.ch = s[i]; exp_q.push_back(e);
        end
        m_pending = 0;
        exp_start = 1;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_start = 0; in_burst = 0;
    m_str = ""; m_loaded = 0; m_pending = 0;
    m_err_seq = 0; m_err_ovf = 0; m_err_tmo = 0;
  endtask

  // Per-cycle strobe comparison against the model's expected stream.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sme_isstring || sme_ispattern) begin
          if (sme_isstring) n_str++; else n_pat++;
          if (sme_isstring && sme_ispattern) check("both_strobes", 1, 0);
          if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("strobe_kind", sme_isstring, e.is_str);
            check("strobe_char", sme_chardata, e.ch);
          end
          exp_start = 0; in_burst = 1;
        end else begin
          check("idle_chardata", sme_chardata, 0);
          if (exp_start) check("first_strobe_late", 0, 1);
          if (in_burst && exp_q.size() != 0) check("strobe_gap", 0, 1);
          exp_start = 0; in_burst = 0;
        end
      end
    end
  end

  task automatic send_byte(input logic k, input logic [7:0] d, input logic l, output bit ok);
    s_valid = 1'b1; s_kind = k; s_data = d; s_last = l; ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (ok) begin @(posedge clk); #1; end
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
  endtask

  task automatic send_rec(input logic kind, input string s, output int acc);
    bit ok;
    acc = 0;
    for (int i = 0; i < s.len(); i++) begin
      send_byte(kind, s[i], i == s.len() - 1, ok);
      if (ok) acc++;
      else begin check("s_ready_wait", 0, 1); break; end
    end
    model_rec(kind, s);
  endtask

  task automatic wait_send_done();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !(sme_isstring || sme_ispattern)) begin done = 1; break; end
      @(posedge clk); #2;
    end
    check("send_done", done, 1);
  endtask

  task automatic answer(input logic m, input logic [IDX_W-1:0] ix);
    check("r_valid_before_answer", r_valid, 0);
    sme_valid = 1'b1; sme_match = m; sme_match_index = ix;
    m_rm = m; m_ri = ix;
    @(posedge clk); #1;
    sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0;
    check("r_valid_rise", r_valid, 1);
    check("r_match_model", r_match, m_rm);
    check("r_index_model", r_index, m_ri);
  endtask

  task automatic consume();
    repeat (2) @(posedge clk);
    #1;
    check("r_valid_held", r_valid, 1);
    check("r_match_held", r_match, m_rm);
    check("r_index_held", r_index, m_ri);
    check("s_ready_in_result", s_ready, 0);
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    check("r_valid_drop", r_valid, 0);
    check("s_ready_idle_gap", s_ready, 0);
    @(posedge clk); #1;
    check("s_ready_reopen", s_ready, 1);
  endtask

  task automatic check_errs();
    check("err_seq", err_seq, m_err_seq);
    check("err_overflow", err_overflow, m_err_ovf);
    check("err_timeout", err_timeout, m_err_tmo);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, k;
    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_strobes", {sme_isstring, sme_ispattern}, 0);
    check("rst_chardata", sme_chardata, 0);
    check("rst_result", {r_valid, r_match, r_index}, 0);
    check("rst_errs", {err_overflow, err_seq, err_timeout}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("s_ready_after_reset", s_ready, 1);

    // pattern with no string loaded
    n_str = 0; n_pat = 0;
    send_rec(KIND_PATTERN, "xy", acc);
    check("seq_s_ready_back", s_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    check("seq_no_strobes", n_str + n_pat, 0);
    check("seq_err_lit", err_seq, 1);
    check_errs();

    // "abcab" then "ca": 5 string strobes then 2 pattern strobes
    n_str = 0; n_pat = 0;
    send_rec(KIND_STRING, "abcab", acc);
    check("abcab_accepted", acc, 5);
    repeat (3) @(posedge clk);
    #1;
    check("str_only_no_send", n_str + n_pat, 0);
    send_rec(KIND_PATTERN, "ca", acc);
    wait_send_done();
    check("abcab_n_str", n_str, 5);
    check("ca_n_pat", n_pat, 2);
    answer(1'b1, 5'd2);
    check("abcab_r_match_lit", r_match, 1);
    check("abcab_r_index_lit", r_index, 2);
    consume();
    check_errs();

    // sme_valid while idle must not produce a result
    sme_valid = 1'b1; sme_match = 1'b1; sme_match_index = 5'd9;
    @(posedge clk); #1;
    sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0;
    @(posedge clk); #1;
    check("idle_sme_valid_ignored", r_valid, 0);

    // second pattern: string already sent, pattern only
    n_str = 0; n_pat = 0;
    send_rec(KIND_PATTERN, "zz", acc);
    wait_send_done();
    check("zz_n_str", n_str, 0);
    check("zz_n_pat", n_pat, 2);
    answer(1'b0, 5'd3);
    check("zz_r_match_lit", r_match, 0);
    check("zz_r_index_lit", r_index, 3);
    consume();

    // 40-byte string overflows to 32, then a timeout with no SME answer
    n_str = 0; n_pat = 0;
    send_rec(KIND_STRING, "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmn", acc);
    check("ovf_accepted", acc, 40);
    check("ovf_flag_lit", err_overflow, 1);
    send_rec(KIND_PATTERN, "q", acc);
    wait_send_done();
    check("ovf_n_str", n_str, 32);
    check("ovf_n_pat", n_pat, 1);
    k = 1;
    for (int i = 0; i < 400 && !r_valid; i++) begin
      @(posedge clk); #2;
      k++;
    end
    m_rm = 1'b0; m_ri = '0; m_err_tmo = 1;
    check("timeout_latency", k, TIMEOUT + 1);
    check("timeout_r_valid", r_valid, 1);
    check("timeout_r_match", r_match, 0);
    check("timeout_r_index", r_index, 0);
    check_errs();
    consume();

    // reset while the string is being sent
    n_str = 0; n_pat = 0;
    send_rec(KIND_STRING, "hello", acc);
    send_rec(KIND_PATTERN, "lo", acc);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("mid_rst_strobes", {sme_isstring, sme_ispattern}, 0);
    check("mid_rst_chardata", sme_chardata, 0);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_result", {r_valid, r_match, r_index}, 0);
    check_errs();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_s_ready_back", s_ready, 1);
    n_str = 0; n_pat = 0;
    send_rec(KIND_PATTERN, "ab", acc);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_strobes", n_str + n_pat, 0);
    check("post_rst_err_seq_lit", err_seq, 1);
    check_errs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
